// File: rtl/dm_param_if.sv
// dm_param_if: request/response bundle for the dm_param data memory.
//
// Handshake: there is no back-pressure. The master presents a request by
// holding req=1 (with we/addr/size/uext/din stable) across one rising edge.
// The request is taken only if busy=0 at that edge; while busy=1 it is
// silently dropped. A load answers one cycle later with a single-cycle
// dout_valid pulse; a rejected access answers with a single-cycle misalign
// pulse instead. dout holds the last load result between pulses.
//
// Signals (master view):
//   req, we, addr[ADDR_WIDTH-1:0], size[1:0], uext, din[31:0]  -> out
//   dout[31:0], dout_valid, misalign, busy                     <- in
interface dm_param_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [1:0]            size;
  logic                  uext;
  logic [31:0]           din;
  logic [31:0]           dout;
  logic                  dout_valid;
  logic                  misalign;
  logic                  busy;

  modport master (
    output req, we, addr, size, uext, din,
    input  dout, dout_valid, misalign, busy
  );

  modport slave (
    input  req, we, addr, size, uext, din,
    output dout, dout_valid, misalign, busy
  );
endinterface

// File: rtl/dm_param.sv
// dm_param: byte-addressable, little-endian 32-bit data memory with
// byte/half/word loads and stores, sign/zero extension, misalignment
// rejection and an optional zero-fill sequence after reset.
//
// Ports:
//   clk          in   single clock, rising edge
//   rst          in   synchronous active-high reset
//   bus          slave modport of dm_param_if (request in, response out)
//   state_dbg_o  out  current FSM state (1 = CLEAR, 0 = IDLE)
module dm_param #(
  parameter int ADDR_WIDTH     = 12,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  dm_param_if.slave    bus,
  output logic         state_dbg_o
);

  localparam int IW    = ADDR_WIDTH - 2;
  localparam int DEPTH = 1 << IW;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e         state_q;
  logic [IW-1:0]  clr_cnt_q;
  logic [31:0]    mem_q [DEPTH];
  logic [31:0]    dout_q, dout_d;
  logic           dv_q, dv_d;
  logic           mis_q, mis_d;

  logic           busy;
  logic           accept;
  logic           legal;
  logic           store_en;
  logic           clr_en;
  logic [IW-1:0]  idx;
  logic [1:0]     lane;
  logic [31:0]    rd_word;
  logic [7:0]     rd_byte;
  logic [15:0]    rd_half;
  logic [31:0]    ld_data;
  logic [3:0]     be;
  logic [31:0]    wdata;

  assign busy   = (state_q == ST_CLEAR);
  assign idx    = bus.addr[ADDR_WIDTH-1:2];
  assign lane   = bus.addr[1:0];
  // Reset wins over a request presented at the same edge.
  assign accept = bus.req & ~busy & ~rst;
  assign clr_en = busy & ~rst;

  always_comb begin
    legal = 1'b0;
    be    = 4'b0000;
    wdata = bus.din;
    unique case (bus.size)
      2'b00: begin
        legal = 1'b1;
        be    = 4'b0001 << lane;
        wdata = {4{bus.din[7:0]}};
      end
      2'b01: begin
        legal = ~lane[0];
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wdata = {2{bus.din[15:0]}};
      end
      2'b10: begin
        legal = (lane == 2'b00);
        be    = 4'b1111;
        wdata = bus.din;
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

  assign store_en = accept & legal & bus.we;

  // Read data is the memory content before this edge's write (only one
  // access per cycle, so a store and a load never collide).
  assign rd_word = mem_q[idx];
  assign rd_byte = rd_word[{lane, 3'b000} +: 8];
  assign rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    ld_data = rd_word;
    unique case (bus.size)
      2'b00:   ld_data = bus.uext ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      2'b01:   ld_data = bus.uext ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: ld_data = rd_word;
    endcase
  end

  always_comb begin
    dout_d = dout_q;
    dv_d   = 1'b0;
    mis_d  = 1'b0;
    if (accept) begin
      if (!legal) begin
        mis_d = 1'b1;
      end else if (!bus.we) begin
        dv_d   = 1'b1;
        dout_d = ld_data;
      end
    end
  end

  // Memory array: no reset; zero-filled word by word by the CLEAR state.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem_q[clr_cnt_q] <= 32'h0000_0000;
    end else if (store_en) begin
      for (int l = 0; l < 4; l++) begin
        if (be[l]) begin
          mem_q[idx][8*l +: 8] <= wdata[8*l +: 8];
        end
      end
    end
  end

  // Control FSM and registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      clr_cnt_q <= '0;
      dout_q    <= 32'h0000_0000;
      dv_q      <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      dout_q <= dout_d;
      dv_q   <= dv_d;
      mis_q  <= mis_d;
      unique case (state_q)
        ST_CLEAR: begin
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (&clr_cnt_q) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Pulses are masked while rst is high so a load answered in the same
  // cycle as an incoming reset never reports a result.
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dv_q & ~rst;
  assign bus.misalign   = mis_q & ~rst;
  assign bus.busy       = busy;
  assign state_dbg_o    = state_q;

endmodule

// File: tb/tb_dm_param.sv
// tb_dm_param: directed scoreboard bench for dm_param (ADDR_WIDTH=12,
// CLEAR_ON_RESET=1).
module tb_dm_param;

  logic clk;
  logic rst;
  logic state_dbg;

  dm_param_if #(.ADDR_WIDTH(12)) bus();

  dm_param #(.ADDR_WIDTH(12), .CLEAR_ON_RESET(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .state_dbg_o (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  // bit 32: 1 = expect misalign pulse, 0 = expect dout_valid pulse
  logic [32:0] exp_q[$];
  logic [31:0] last_dout;
  int total;
  int bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [32:0] e;
    if (bus.dout_valid || bus.misalign) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output: dout_valid=%0b misalign=%0b dout=%08h, none expected",
                 bus.dout_valid, bus.misalign, bus.dout);
      end else begin
        e = exp_q.pop_front();
        if ({bus.misalign, bus.dout_valid} != (e[32] ? 2'b10 : 2'b01) || bus.dout !== e[31:0]) begin
          bad++;
          $display("FAIL response: got mis=%0b dv=%0b dout=%08h expected mis=%0b dv=%0b dout=%08h",
                   bus.misalign, bus.dout_valid, bus.dout, e[32], ~e[32], e[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic w, input logic [11:0] a, input logic [1:0] s,
                       input logic u, input logic [31:0] d);
    bus.req  = 1'b1;
    bus.we   = w;
    bus.addr = a;
    bus.size = s;
    bus.uext = u;
    bus.din  = d;
    @(posedge clk);
    #1;
    bus.req  = 1'b0;
  endtask

  task automatic store(input logic [11:0] a, input logic [1:0] s, input logic [31:0] d);
    issue(1'b1, a, s, 1'b0, d);
  endtask

  task automatic load(input logic [11:0] a, input logic [1:0] s, input logic u,
                      input logic [31:0] exp);
    exp_q.push_back({1'b0, exp});
    last_dout = exp;
    issue(1'b0, a, s, u, 32'h0);
  endtask

  task automatic reject(input logic w, input logic [11:0] a, input logic [1:0] s,
                        input logic [31:0] d);
    exp_q.push_back({1'b1, last_dout});
    issue(w, a, s, 1'b0, d);
  endtask

  // Counts negedges with busy high; optionally throws random requests at
  // the DUT while it is busy (none of them may produce any output).
  task automatic count_busy(input bit poke, input int limit, output int n);
    n = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
      n++;
      if (poke) begin
        bus.req  = 1'($urandom_range(0, 1));
        bus.we   = 1'($urandom_range(0, 1));
        bus.addr = 12'($urandom_range(0, 4095));
        bus.size = 2'($urandom_range(0, 3));
        bus.uext = 1'($urandom_range(0, 1));
        bus.din  = $urandom;
      end
    end
    bus.req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    total = 0;
    bad = 0;
    last_dout = 32'h0;
    rst = 1'b1;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.size = 2'b00;
    bus.uext = 1'b0; bus.din = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_dout", bus.dout, 32'h0);
    check("reset_dout_valid", 32'(bus.dout_valid), 32'h0);
    check("reset_misalign", 32'(bus.misalign), 32'h0);
    check("reset_busy", 32'(bus.busy), 32'h1);
    @(posedge clk); #1;
    rst = 1'b0;

    count_busy(1'b0, 5000, n);
    check("clear_cycles", 32'(n), 32'd1024);

    // cleared contents
    load(12'h000, 2'b10, 1'b0, 32'h0000_0000);
    load(12'hFFC, 2'b10, 1'b0, 32'h0000_0000);

    // extension cases
    store(12'h010, 2'b10, 32'h80FF_7F01);
    load(12'h013, 2'b00, 1'b0, 32'hFFFF_FF80);
    load(12'h012, 2'b00, 1'b1, 32'h0000_00FF);
    load(12'h010, 2'b01, 1'b0, 32'h0000_7F01);
    load(12'h012, 2'b01, 1'b0, 32'hFFFF_80FF);
    load(12'h012, 2'b01, 1'b1, 32'h0000_80FF);
    load(12'h010, 2'b00, 1'b0, 32'h0000_0001);
    load(12'h011, 2'b10, 1'b1, 32'h8000_0000 | 32'h0) ;
    exp_q.pop_back();
    exp_q.push_back({1'b1, 32'h0000_0001});
    last_dout = 32'h0000_0001;

    // lane merging; a store leaves dout alone
    store(12'h020, 2'b10, 32'h1122_3344);
    store(12'h021, 2'b00, 32'hFFFF_FFAA);
    @(negedge clk);
    check("dout_hold_after_store", bus.dout, last_dout);
    load(12'h020, 2'b10, 1'b0, 32'h1122_AA44);
    store(12'h022, 2'b01, 32'h0000_5566);
    load(12'h020, 2'b10, 1'b0, 32'h5566_AA44);
    load(12'h022, 2'b01, 1'b1, 32'h0000_5566);

    // rejected accesses
    store(12'h030, 2'b10, 32'hCAFE_F00D);
    reject(1'b1, 12'h031, 2'b01, 32'h0000_FFFF);
    reject(1'b0, 12'h032, 2'b10, 32'h0);
    reject(1'b1, 12'h030, 2'b11, 32'h1234_5678);
    load(12'h030, 2'b10, 1'b0, 32'hCAFE_F00D);

    // store then immediate load; back-to-back ordered loads
    store(12'h004, 2'b10, 32'h4444_4444);
    store(12'h008, 2'b10, 32'h8888_8888);
    store(12'h040, 2'b10, 32'hDEAD_BEEF);
    load(12'h040, 2'b10, 1'b0, 32'hDEAD_BEEF);
    load(12'h000, 2'b10, 1'b0, 32'h0000_0000);
    load(12'h004, 2'b10, 1'b0, 32'h4444_4444);
    load(12'h008, 2'b10, 1'b0, 32'h8888_8888);
    idle(3);
    check("queue_drained_1", 32'(exp_q.size()), 32'h0);

    // load immediately followed by reset: no result may appear
    issue(1'b0, 12'h040, 2'b10, 1'b0, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    last_dout = 32'h0;
    @(negedge clk);
    check("dout_after_reset", bus.dout, 32'h0);

    // reset at clear cycle 500 restarts the clear
    for (int i = 0; i < 499; i++) @(negedge clk);
    check("busy_mid_clear", 32'(bus.busy), 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    count_busy(1'b1, 5000, n);
    check("restart_clear_cycles", 32'(n), 32'd1024);

    // memory fully re-zeroed, nothing written while busy
    load(12'h040, 2'b10, 1'b0, 32'h0000_0000);
    load(12'h010, 2'b10, 1'b0, 32'h0000_0000);
    load(12'h008, 2'b10, 1'b0, 32'h0000_0000);
    idle(3);
    check("queue_drained_2", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dm_param.md
DM_PARAM -- requirements
Module: dm_param

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, byte-address width; memory holds 2^(ADDR_WIDTH-2) 32-bit words (default 1024 words / 4 KiB).
REQ-002 Parameter CLEAR_ON_RESET, default 1, when 1 the memory SHALL be zero-filled after every reset.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req  input  1  access request, sampled each rising edge.
REQ-006 we  input  1  1 = store, 0 = load; meaningful only with req.
REQ-007 addr  input  ADDR_WIDTH  byte address.
REQ-008 size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-009 uext  input  1  load extension: 1 = zero-extend, 0 = sign-extend.
REQ-010 din  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 dout  output  32  load result, right-aligned and extended.
REQ-012 dout_valid  output  1  one-cycle pulse marking dout as a new load result.
REQ-013 misalign  output  1  one-cycle pulse marking a rejected access.
REQ-014 busy  output  1  high while the clear sequence runs; requests are ignored.

Function
REQ-015 Word index = addr[ADDR_WIDTH-1:2]; lane select = addr[1:0]; little-endian (lane 0 = bits [7:0]).
REQ-016 Accepted request: req=1, busy=0, rst=0 at a rising edge (cycle N).
REQ-017 Store: byte writes lane addr[1:0] only; half writes lanes {addr[1],0} and {addr[1],1}; word writes all four; other lanes unchanged.
REQ-018 Load: 1-cycle latency; dout and dout_valid=1 at cycle N+1, data taken from memory contents at cycle N.
REQ-019 Load extension: byte/half sign-extended from bit 7/15 when uext=0, zero-extended when uext=1; word ignores uext.
REQ-020 Store at N followed by load of same word at N+1 SHALL return the stored data.
REQ-021 Back-to-back loads every cycle SHALL yield one dout_valid pulse per load, in order.
REQ-022 Accepted store produces no dout_valid; dout holds its previous value.
REQ-023 Misaligned (half with addr[0]=1, word with addr[1:0]!=00) or size=11: no memory write, dout_valid=0, misalign=1 at N+1, dout unchanged.
REQ-024 dout holds the last load result until the next valid load.
REQ-025 FSM states CLEAR and IDLE; busy=1 exactly in CLEAR.
REQ-026 CLEAR: each cycle with rst=0 writes 0x00000000 to word clr_cnt and increments clr_cnt; the cycle writing word 2^(ADDR_WIDTH-2)-1 transitions to IDLE; clearing takes exactly 2^(ADDR_WIDTH-2) cycles after rst falls.
REQ-027 Requests with busy=1 SHALL be dropped: no write, no dout_valid, no misalign.
REQ-028 IDLE stays IDLE until rst.

Reset
REQ-029 rst=1 at an edge: dout=0, dout_valid=0, misalign=0, clr_cnt=0; state=CLEAR (busy=1) when CLEAR_ON_RESET=1, else IDLE (busy=0) with memory contents undefined.
REQ-030 Reset overrides any request in the same cycle; a load accepted at N with rst=1 at N+1 SHALL produce no dout_valid.
REQ-031 rst asserted mid-clear restarts the clear at word 0.

Verification
REQ-032 Reset, CLEAR_ON_RESET=1, ADDR_WIDTH=12 -> busy high for exactly 1024 cycles after rst falls; word loads of addr 0x000 and 0xFFC then return 0x00000000.
REQ-033 Store word 0x80FF7F01 at 0x010; load byte 0x013 uext=0 -> 0xFFFFFF80; byte 0x012 uext=1 -> 0x000000FF; half 0x010 uext=0 -> 0x00007F01.
REQ-034 Store byte 0xAA at 0x021 over word 0x11223344 at 0x020 -> word load 0x020 returns 0x1122AA44.
REQ-035 Half store at 0x031, word load at 0x032, size=11 request -> misalign pulses once each, no dout_valid, memory at 0x030 unchanged.
REQ-036 Store 0xDEADBEEF at 0x040 cycle N, word load 0x040 at N+1 -> dout=0xDEADBEEF, dout_valid=1 at N+2; loads of 0x000, 0x004, 0x008 issued on consecutive cycles -> three consecutive dout_valid pulses, in order.
REQ-037 rst pulsed at clear cycle 500 -> busy stays high 1024 further cycles; requests during busy produce no outputs.
